operand_issue: RTL and testbench
================================

OPERAND_ISSUE -- requirements
Module: operand_issue

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: in_valid input 1, in_ready output 1; decoded-instruction handshake.
REQ-004 SHALL have ports: in_op input 3 (ALU opcode 000 add, 001 sub, 010 and, 011 or, 100 slt, 101 mul, 110 div, 111 reserved), in_rs/in_rt/in_rd input 3 each (register indices).
REQ-005 SHALL have ports: in_use_imm input 1 (b from in_imm instead of rt), in_imm input 16.
REQ-006 SHALL have ports: alu_valid output 1, alu_ready input 1, alu_control output 3, alu_a output 16, alu_b output 16, alu_rd output 3; issue to ALU stage.
REQ-007 SHALL have ports: wb_valid input 1, wb_rd input 3, wb_data input 16; ALU result writeback.
REQ-008 SHALL have port: err_count output 8, count of reserved opcodes accepted.

Function
REQ-009 SHALL hold an 8 x 16-bit register file; r0 reads 0 always, writes to r0 discarded.
REQ-010 SHALL keep pending[7:0] scoreboard; pending[0] always 0.
REQ-011 Hazard SHALL exist when pending[in_rs], or pending[in_rt] with in_use_imm=0, or pending[in_rd] (WAW).
REQ-012 in_ready SHALL equal (!alu_valid || alu_ready) && !hazard && !rst, combinationally.
REQ-013 Accept = in_valid && in_ready; on accept of op 000..110, output register loads next edge: alu_control=in_op, alu_a=R[rs], alu_b=in_use_imm ? in_imm : R[rt], alu_rd=in_rd; alu_valid=1; latency exactly 1 cycle.
REQ-014 On accept with in_rd!=0 and op valid, pending[in_rd] SHALL set at the same edge.
REQ-015 Payload SHALL stay stable while alu_valid && !alu_ready; alu_valid drops after handshake unless a new accept occurs that cycle (back-to-back at full rate).
REQ-016 Op 111 SHALL be accepted (in_ready rules unchanged), produce no alu_valid, set no pending bit, increment err_count; err_count saturates at 255.
REQ-017 wb_valid SHALL write wb_data to R[wb_rd] and clear pending[wb_rd] at the edge; wb to a non-pending register still writes, scoreboard unchanged.
REQ-018 Same-edge wb clear and accept set on same register: set wins.
REQ-019 Register reads SHALL see the register file value before the current edge's write unless bypass enabled (REQ-024).
REQ-020 Reserved-op accept never blocked by alu_valid stall? No: same in_ready rule applies.

Reset
REQ-021 While rst=1: all registers 0, pending 0, alu_valid 0, alu_control/alu_a/alu_b/alu_rd 0, err_count 0, in_ready 0, wb_valid ignored.
REQ-022 Reset mid-transfer SHALL drop the held ALU payload; no replay after reset.
REQ-023 First accept possible in first cycle with rst=0.

Configuration
REQ-024 Macro OPERAND_BYPASS_EN defined: a same-cycle wb_valid with wb_rd!=0 clears the hazard for that register in that cycle and the issued operand takes wb_data (rs and rt independently); accept proceeds same cycle.
REQ-025 OPERAND_BYPASS_EN undefined: hazard remains that cycle; instruction accepted no earlier than the cycle after wb, reading the written value from the register file.

Verification
REQ-026 Reset, then wb r1=0x0005, wb r2=0x0003; issue op 001 rs=1 rt=2 rd=3 -> next cycle alu_valid=1, alu_control=001, a=0x0005, b=0x0003, alu_rd=3, pending[3]=1.
REQ-027 Issue add rd=3, then issue rs=3 rt=1 with no wb -> in_ready=0; wb r3=0x0008 -> bypass build accepts same cycle with a=0x0008, non-bypass build accepts one cycle later with a=0x0008.
REQ-028 Hold alu_ready=0 for 4 cycles with alu_valid=1 -> payload unchanged, in_ready=0; alu_ready=1 with in_valid=1 -> new payload next cycle, alu_valid stays 1.
REQ-029 Issue op 111 300 times -> no alu_valid, err_count=255; rst=1 -> err_count=0.
REQ-030 wb r0=0xFFFF, issue rs=0 in_use_imm=1 in_imm=0x1234 -> alu_a=0x0000, alu_b=0x1234; rst asserted while alu_valid=1 -> alu_valid=0 next cycle.

Source files
------------

// File: rtl/operand_issue.sv
// Operand issue stage: register file, pending-write scoreboard and a one-deep ALU issue register.
// Define OPERAND_BYPASS_EN to forward a same-cycle writeback into hazard resolution and operands.
module operand_issue #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [2:0]        in_rs,
  input  logic [2:0]        in_rt,
  input  logic [2:0]        in_rd,
  input  logic              in_use_imm,
  input  logic [DATA_W-1:0] in_imm,
  output logic              alu_valid,
  input  logic              alu_ready,
  output logic [2:0]        alu_control,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_rd,
  input  logic              wb_valid,
  input  logic [2:0]        wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic [7:0]        err_count
);

  localparam logic [2:0] OP_RSVD = 3'b111;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [DATA_W-1:0] rf [8];
  logic [7:0]        pending;
  logic [7:0]        pending_nxt;
  logic [7:0]        pend_eff;
  logic [7:0]        wb_hit;
  logic [7:0]        set_mask;
  logic              hazard;
  logic              accept;
  logic              rsvd;
  logic [DATA_W-1:0] opa_p0;
  logic [DATA_W-1:0] opb_p0;

  logic              vld_p1;
  logic [2:0]        ctrl_p1;
  logic [DATA_W-1:0] a_p1;
  logic [DATA_W-1:0] b_p1;
  logic [2:0]        rd_p1;
  logic [7:0]        err_p1;

  // Decode / hazard / operand read (combinational, stage 0)
  always_comb begin
    wb_hit = '0;
    if (wb_valid && wb_rd != 3'd0) wb_hit = 8'b1 << wb_rd;
`ifdef OPERAND_BYPASS_EN
    pend_eff = pending & ~wb_hit;
    opa_p0   = wb_hit[in_rs] ? wb_data : rf[in_rs];
    opb_p0   = in_use_imm ? in_imm : (wb_hit[in_rt] ? wb_data : rf[in_rt]);
`else
    pend_eff = pending;
    opa_p0   = rf[in_rs];
    opb_p0   = in_use_imm ? in_imm : rf[in_rt];
`endif
    hazard   = pend_eff[in_rs] || (pend_eff[in_rt] && !in_use_imm) || pend_eff[in_rd];
    in_ready = (!vld_p1 || alu_ready) && !hazard && !rst;
    accept   = in_valid && in_ready;
    rsvd     = (in_op == OP_RSVD);
    set_mask = '0;
    if (accept && !rsvd && in_rd != 3'd0) set_mask = 8'b1 << in_rd;
    // An accept setting a bit beats a writeback clearing it on the same edge.
    pending_nxt    = (pending & ~wb_hit) | set_mask;
    pending_nxt[0] = 1'b0;
  end

  // Stage 0 -> stage 1: register file, scoreboard and issue register
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) rf[i] <= '0;
      pending <= '0;
      vld_p1  <= 1'b0;
      ctrl_p1 <= '0;
      a_p1    <= '0;
      b_p1    <= '0;
      rd_p1   <= '0;
      err_p1  <= '0;
    end else begin
      if (wb_valid && wb_rd != 3'd0) rf[wb_rd] <= wb_data;
      pending <= pending_nxt;
      if (accept && !rsvd) begin
        vld_p1  <= 1'b1;
        ctrl_p1 <= in_op;
        a_p1    <= opa_p0;
        b_p1    <= opb_p0;
        rd_p1   <= in_rd;
      end else if (alu_ready) begin
        vld_p1  <= 1'b0;
      end
      if (accept && rsvd) err_p1 <= sat_inc(err_p1);
    end
  end

  assign alu_valid   = vld_p1;
  assign alu_control = ctrl_p1;
  assign alu_a       = a_p1;
  assign alu_b       = b_p1;
  assign alu_rd      = rd_p1;
  assign err_count   = err_p1;

endmodule

// File: tb/tb_operand_issue.sv
// Directed self-checking bench for operand_issue (default and OPERAND_BYPASS_EN builds).
module tb_operand_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op, in_rs, in_rt, in_rd;
  logic        in_use_imm;
  logic [15:0] in_imm;
  logic        alu_valid;
  logic        alu_ready;
  logic [2:0]  alu_control;
  logic [15:0] alu_a, alu_b;
  logic [2:0]  alu_rd;
  logic        wb_valid;
  logic [2:0]  wb_rd;
  logic [15:0] wb_data;
  logic [7:0]  err_count;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  operand_issue dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_use_imm(in_use_imm), .in_imm(in_imm),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_control(alu_control),
    .alu_a(alu_a), .alu_b(alu_b), .alu_rd(alu_rd),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .err_count(err_count)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [2:0] op, input logic [2:0] rs, input logic [2:0] rt,
                           input logic [2:0] rd, input logic use_imm, input logic [15:0] imm);
    in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_use_imm = use_imm; in_imm = imm;
  endtask

  task automatic test_reset;
    logic [38:0] got;
    rst = 1'b1; alu_ready = 1'b1; in_valid = 1'b1;
    set_instr(3'd0, 3'd1, 3'd0, 3'd0, 1'b1, 16'h0007);
    wb_valid = 1'b1; wb_rd = 3'd1; wb_data = 16'h0055;
    tick; tick;
    n_total++;
    if (in_ready !== 1'b0) $display("FAIL reset_in_ready got=%b want=0", in_ready);
    else n_pass++;
    got = {alu_valid, alu_control, alu_a, alu_b, alu_rd};
    n_total++;
    if (got !== 39'd0 || err_count !== 8'd0)
      $display("FAIL reset_outputs got=%h err=%0d want=0 err=0", got, err_count);
    else n_pass++;
    // first cycle out of reset must already accept; r1 must not hold the ignored wb
    rst = 1'b0; wb_valid = 1'b0;
    #1;
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL first_accept_ready got=%b want=1", in_ready);
    else n_pass++;
    tick;
    in_valid = 1'b0;
    got = {alu_valid, alu_control, alu_a, alu_b, alu_rd};
    n_total++;
    if (got !== {1'b1, 3'd0, 16'h0000, 16'h0007, 3'd0})
      $display("FAIL first_accept_payload got=%h want=%h", got, {1'b1, 3'd0, 16'h0000, 16'h0007, 3'd0});
    else n_pass++;
    tick;
    n_total++;
    if (alu_valid !== 1'b0) $display("FAIL valid_drop got=%b want=0", alu_valid);
    else n_pass++;
  endtask

  task automatic test_sub;
    logic [38:0] got;
    wb_valid = 1'b1; wb_rd = 3'd1; wb_data = 16'h0005; tick;
    wb_rd = 3'd2; wb_data = 16'h0003; tick;
    wb_valid = 1'b0;
    in_valid = 1'b1; set_instr(3'd1, 3'd1, 3'd2, 3'd3, 1'b0, 16'h0000);
    #1;
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL sub_ready got=%b want=1", in_ready);
    else n_pass++;
    tick;
    got = {alu_valid, alu_control, alu_a, alu_b, alu_rd};
    n_total++;
    if (got !== {1'b1, 3'd1, 16'h0005, 16'h0003, 3'd3})
      $display("FAIL sub_payload got=%h want=%h", got, {1'b1, 3'd1, 16'h0005, 16'h0003, 3'd3});
    else n_pass++;
    set_instr(3'd0, 3'd3, 3'd0, 3'd0, 1'b1, 16'h0000);
    #1;
    n_total++;
    if (in_ready !== 1'b0) $display("FAIL sub_pending3 got=%b want=0", in_ready);
    else n_pass++;
    in_valid = 1'b0;
    wb_valid = 1'b1; wb_rd = 3'd3; wb_data = 16'h0000; tick;
    wb_valid = 1'b0;
  endtask

  task automatic test_hazard;
    logic [38:0] got;
    in_valid = 1'b1; set_instr(3'd0, 3'd1, 3'd2, 3'd3, 1'b0, 16'h0000);
    tick;
    set_instr(3'd0, 3'd3, 3'd1, 3'd4, 1'b0, 16'h0000);
    #1;
    n_total++;
    if (in_ready !== 1'b0) $display("FAIL raw_stall got=%b want=0", in_ready);
    else n_pass++;
    tick;
    n_total++;
    if (in_ready !== 1'b0 || alu_valid !== 1'b0)
      $display("FAIL raw_hold got=%b/%b want=0/0", in_ready, alu_valid);
    else n_pass++;
    wb_valid = 1'b1; wb_rd = 3'd3; wb_data = 16'h0008;
    #1;
`ifdef OPERAND_BYPASS_EN
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL bypass_ready got=%b want=1", in_ready);
    else n_pass++;
    tick;
    wb_valid = 1'b0;
`else
    n_total++;
    if (in_ready !== 1'b0) $display("FAIL nobypass_ready got=%b want=0", in_ready);
    else n_pass++;
    tick;
    wb_valid = 1'b0;
    #1;
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL nobypass_late_ready got=%b want=1", in_ready);
    else n_pass++;
    tick;
`endif
    in_valid = 1'b0;
    got = {alu_valid, alu_control, alu_a, alu_b, alu_rd};
    n_total++;
    if (got !== {1'b1, 3'd0, 16'h0008, 16'h0005, 3'd4})
      $display("FAIL raw_payload got=%h want=%h", got, {1'b1, 3'd0, 16'h0008, 16'h0005, 3'd4});
    else n_pass++;
    wb_valid = 1'b1; wb_rd = 3'd4; wb_data = 16'h0000; tick;
    wb_valid = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [35:0] got;
    alu_ready = 1'b1; in_valid = 1'b1;
    set_instr(3'd2, 3'd1, 3'd2, 3'd0, 1'b0, 16'h0000);
    tick;
    got = {alu_valid, alu_control, alu_a, alu_b};
    n_total++;
    if (got !== {1'b1, 3'd2, 16'h0005, 16'h0003})
      $display("FAIL b2b_first got=%h want=%h", got, {1'b1, 3'd2, 16'h0005, 16'h0003});
    else n_pass++;
    set_instr(3'd3, 3'd3, 3'd1, 3'd0, 1'b0, 16'h0000);
    tick;
    got = {alu_valid, alu_control, alu_a, alu_b};
    n_total++;
    if (got !== {1'b1, 3'd3, 16'h0008, 16'h0005})
      $display("FAIL b2b_second got=%h want=%h", got, {1'b1, 3'd3, 16'h0008, 16'h0005});
    else n_pass++;
    // same-edge writeback clear and accept set on r6: the set must survive
    set_instr(3'd4, 3'd1, 3'd2, 3'd6, 1'b0, 16'h0000);
    wb_valid = 1'b1; wb_rd = 3'd6; wb_data = 16'h0042;
    tick;
    wb_valid = 1'b0;
    set_instr(3'd0, 3'd6, 3'd0, 3'd0, 1'b1, 16'h0001);
    #1;
    n_total++;
    if (in_ready !== 1'b0) $display("FAIL set_wins got=%b want=0", in_ready);
    else n_pass++;
    in_valid = 1'b0;
    wb_valid = 1'b1; wb_rd = 3'd6; wb_data = 16'h0042; tick;
    wb_valid = 1'b0; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    n_total++;
    if (alu_a !== 16'h0042 || alu_b !== 16'h0001)
      $display("FAIL r6_read got=%h/%h want=0042/0001", alu_a, alu_b);
    else n_pass++;
    tick;
  endtask

  task automatic test_stall;
    logic [35:0] got;
    alu_ready = 1'b0; in_valid = 1'b1;
    set_instr(3'd2, 3'd1, 3'd0, 3'd0, 1'b1, 16'h00FF);
    tick;
    set_instr(3'd3, 3'd2, 3'd1, 3'd0, 1'b0, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      got = {alu_valid, alu_control, alu_a, alu_b};
      n_total++;
      if (got !== {1'b1, 3'd2, 16'h0005, 16'h00FF} || in_ready !== 1'b0)
        $display("FAIL stall_hold%0d got=%h rdy=%b want=%h rdy=0", i, got, in_ready,
                 {1'b1, 3'd2, 16'h0005, 16'h00FF});
      else n_pass++;
      tick;
    end
    alu_ready = 1'b1;
    #1;
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL stall_release_ready got=%b want=1", in_ready);
    else n_pass++;
    tick;
    in_valid = 1'b0;
    got = {alu_valid, alu_control, alu_a, alu_b};
    n_total++;
    if (got !== {1'b1, 3'd3, 16'h0003, 16'h0005})
      $display("FAIL stall_next got=%h want=%h", got, {1'b1, 3'd3, 16'h0003, 16'h0005});
    else n_pass++;
    tick;
    n_total++;
    if (alu_valid !== 1'b0) $display("FAIL stall_drain got=%b want=0", alu_valid);
    else n_pass++;
  endtask

  task automatic test_reserved;
    int bad = 0;
    alu_ready = 1'b1; in_valid = 1'b1;
    set_instr(3'd7, 3'd0, 3'd0, 3'd5, 1'b1, 16'h0000);
    for (int i = 0; i < 300; i++) begin
      tick;
      if (alu_valid !== 1'b0) bad++;
      if (i == 9) begin
        n_total++;
        if (err_count !== 8'd10) $display("FAIL err_count10 got=%0d want=10", err_count);
        else n_pass++;
      end
    end
    n_total++;
    if (bad != 0) $display("FAIL rsvd_no_valid got=%0d want=0 valid cycles", bad);
    else n_pass++;
    n_total++;
    if (err_count !== 8'd255) $display("FAIL err_sat got=%0d want=255", err_count);
    else n_pass++;
    set_instr(3'd0, 3'd5, 3'd0, 3'd0, 1'b1, 16'h0001);
    #1;
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL rsvd_no_pending got=%b want=1", in_ready);
    else n_pass++;
    in_valid = 1'b0;
    rst = 1'b1; tick; rst = 1'b0;
    n_total++;
    if (err_count !== 8'd0) $display("FAIL err_reset got=%0d want=0", err_count);
    else n_pass++;
  endtask

  task automatic test_r0;
    logic [35:0] got;
    wb_valid = 1'b1; wb_rd = 3'd0; wb_data = 16'hFFFF; tick;
    wb_valid = 1'b0;
    alu_ready = 1'b0; in_valid = 1'b1;
    set_instr(3'd0, 3'd0, 3'd0, 3'd0, 1'b1, 16'h1234);
    tick;
    in_valid = 1'b0;
    got = {alu_valid, alu_control, alu_a, alu_b};
    n_total++;
    if (got !== {1'b1, 3'd0, 16'h0000, 16'h1234})
      $display("FAIL r0_read got=%h want=%h", got, {1'b1, 3'd0, 16'h0000, 16'h1234});
    else n_pass++;
    rst = 1'b1; tick;
    n_total++;
    if (alu_valid !== 1'b0 || alu_b !== 16'h0000)
      $display("FAIL reset_drop got=%b/%h want=0/0000", alu_valid, alu_b);
    else n_pass++;
    rst = 1'b0; alu_ready = 1'b1; tick;
    n_total++;
    if (alu_valid !== 1'b0) $display("FAIL no_replay got=%b want=0", alu_valid);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; alu_ready = 1'b1; wb_valid = 1'b0;
    wb_rd = 3'd0; wb_data = 16'h0000;
    set_instr(3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0000);
    test_reset;
    test_sub;
    test_hazard;
    test_back_to_back;
    test_stall;
    test_reserved;
    test_r0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
